// File: rtl/edge_monitor_pkg.sv
// edge_monitor_pkg: per-channel edge-select encoding shared by the monitor and its users
package edge_monitor_pkg;
    typedef logic [1:0] em_mode_t;
    localparam em_mode_t EM_MODE_OFF  = 2'b00;
    localparam em_mode_t EM_MODE_RISE = 2'b01;
    localparam em_mode_t EM_MODE_FALL = 2'b10;
    localparam em_mode_t EM_MODE_BOTH = 2'b11;
endpackage

// File: rtl/edge_monitor_if.sv
// edge_monitor_if: raw inputs, controls and event outputs of the multi-channel edge monitor
interface edge_monitor_if #(parameter int CH = 4, parameter int CNT_W = 8);
    logic [CH-1:0]       sig_in;
    logic [2*CH-1:0]     mode;
    logic [CH-1:0]       clr_flag;
    logic [CH-1:0]       clr_cnt;
    logic [CH-1:0]       filt_out;
    logic [CH-1:0]       rise_pulse;
    logic [CH-1:0]       fall_pulse;
    logic [CH-1:0]       evt_flag;
    logic [CH*CNT_W-1:0] edge_cnt;
    logic                any_evt;
    modport master (output sig_in, mode, clr_flag, clr_cnt,
                    input filt_out, rise_pulse, fall_pulse, evt_flag, edge_cnt, any_evt);
    modport slave (input sig_in, mode, clr_flag, clr_cnt,
                   output filt_out, rise_pulse, fall_pulse, evt_flag, edge_cnt, any_evt);
endinterface

// File: rtl/edge_monitor_ch.sv
// edge_monitor_ch: one channel - synchroniser, debounce filter, edge qualify, sticky flag, saturating counter
module edge_monitor_ch
    import edge_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  em_mode_t         mode,
    input  logic             clr_flag,
    input  logic             clr_cnt,
    output logic             filt,
    output logic             rise,
    output logic             fall,
    output logic             flag,
    output logic [CNT_W-1:0] cnt
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    logic          s;
    logic [DW-1:0] dcnt;
    logic          acc, q_rise, q_fall, q;
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = sig;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync;
        always_ff @(posedge clk) begin
            if (rst) sync <= '0;
            else sync <= SYNC_STAGES'({sync, sig});
        end
        assign s = sync[SYNC_STAGES-1];
    end
    // accept a new level once it has differed from filt for DEBOUNCE consecutive samples
    assign acc    = (s != filt) && (dcnt == DW'(DEBOUNCE - 1));
    assign q_rise = acc && s && (mode == EM_MODE_RISE || mode == EM_MODE_BOTH);
    assign q_fall = acc && !s && (mode == EM_MODE_FALL || mode == EM_MODE_BOTH);
    assign q      = q_rise || q_fall;
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
            filt <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            flag <= 1'b0;
            cnt  <= '0;
        end else begin
            dcnt <= (s == filt || acc) ? '0 : dcnt + DW'(1);
            filt <= acc ? s : filt;
            rise <= q_rise;
            fall <= q_fall;
            flag <= q || (flag && !clr_flag);
            cnt  <= clr_cnt ? CNT_W'(q) : cnt + CNT_W'(q && cnt != '1);
        end
    end
endmodule

// File: rtl/edge_monitor.sv
// edge_monitor: CH independent debounced edge-detect channels with sticky flags and counters
module edge_monitor
    import edge_monitor_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input logic          clk,
    input logic          rst,
    edge_monitor_if.slave bus
);
    logic [CH-1:0]       filt, rise, fall, flag;
    logic [CH*CNT_W-1:0] cnt;
    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_monitor_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig     (bus.sig_in[i]),
            .mode    (em_mode_t'(bus.mode[2*i +: 2])),
            .clr_flag(bus.clr_flag[i]),
            .clr_cnt (bus.clr_cnt[i]),
            .filt    (filt[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .flag    (flag[i]),
            .cnt     (cnt[CNT_W*i +: CNT_W])
        );
    end
    assign bus.filt_out   = filt;
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;
    assign bus.evt_flag   = flag;
    assign bus.edge_cnt   = cnt;
    assign bus.any_evt    = |flag;
endmodule
